// File: rtl/programmable_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | programmable_clock_divider                                                 |
// | Runtime-loadable divider: registered divided clock plus period-start tick. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module programmable_clock_divider #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 50
) (
    input  logic             Input_Clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic [WIDTH-1:0] Divisor,
    input  logic             Load,
    output logic             Output_Clk,
    output logic             Tick,
    output logic             Update_Pending,
    output logic [WIDTH-1:0] Count
);

    localparam logic [WIDTH-1:0] C_DEFAULT_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] C_MIN_DIV     = WIDTH'(2);

    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic             r_pending;
    logic [WIDTH-1:0] r_count;
    logic             r_out_clk;
    logic             r_tick;

    logic             w_wrap;
    logic [WIDTH-1:0] w_clamped;
    logic [WIDTH-1:0] w_div_next;
    logic [WIDTH-1:0] w_count_next;

    // ">=" rather than "==" so a count stranded above a shrunken divisor still wraps
    assign w_wrap       = (r_count >= (r_div - 1'b1));
    assign w_clamped    = (Divisor < C_MIN_DIV) ? C_MIN_DIV : Divisor;
    assign w_div_next   = (w_wrap && r_pending) ? r_pend : r_div;
    assign w_count_next = w_wrap ? '0 : (r_count + 1'b1);

    always_ff @(posedge Input_Clk) begin
        if (Reset) begin
            r_div     <= C_DEFAULT_DIV;
            r_pend    <= C_DEFAULT_DIV;
            r_pending <= 1'b0;
            r_count   <= C_DEFAULT_DIV - 1'b1;
            r_out_clk <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            if (Enable) begin
                r_count   <= w_count_next;
                r_div     <= w_div_next;
                r_tick    <= w_wrap;
                r_out_clk <= (w_count_next < (w_div_next >> 1));
            end else begin
                r_tick    <= 1'b0;
            end

            // A load on a wrap edge survives the wrap and applies one period later
            if (Load) begin
                r_pend    <= w_clamped;
                r_pending <= 1'b1;
            end else if (Enable && w_wrap) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign Output_Clk     = r_out_clk;
    assign Tick           = r_tick;
    assign Update_Pending = r_pending;
    assign Count          = r_count;

endmodule
`default_nettype wire

// File: tb/tb_programmable_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_programmable_clock_divider                                              |
// | Directed self-checking bench for programmable_clock_divider.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_programmable_clock_divider;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 50;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] divisor;
    logic             load;
    logic             out_clk;
    logic             tick;
    logic             pending;
    logic [WIDTH-1:0] count;

    int checks;
    int errors;

    programmable_clock_divider #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .Input_Clk      (clk),
        .Reset          (rst),
        .Enable         (enable),
        .Divisor        (divisor),
        .Load           (load),
        .Output_Clk     (out_clk),
        .Tick           (tick),
        .Update_Pending (pending),
        .Count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int c, input int t, input int o, input int p);
        chk({tag, ".count"},   int'(count),   c);
        chk({tag, ".tick"},    int'(tick),    t);
        chk({tag, ".out_clk"}, int'(out_clk), o);
        chk({tag, ".pending"}, int'(pending), p);
    endtask

    // One clock edge with the given inputs; outputs are sampled 1 time unit later
    task automatic step(input logic en, input logic ld, input logic [WIDTH-1:0] dv);
        enable  = en;
        load    = ld;
        divisor = dv;
        @(posedge clk);
        #1;
        load    = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step(1'b1, 1'b0, '0);
        expect_state(tag, DEFAULT_DIV - 1, 0, 0, 0);
        rst = 1'b0;
    endtask

    // n enabled edges under divisor div, starting at phase start; expected
    // waveform follows directly from the period definition
    task automatic run(input string tag, input int n, input int div, input int start, input int pend);
        for (int k = 0; k < n; k++) begin
            int ph;
            step(1'b1, 1'b0, '0);
            ph = (start + k) % div;
            expect_state(tag, ph, (ph == 0) ? 1 : 0, (ph < div / 2) ? 1 : 0, pend);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        enable  = 1'b0;
        load    = 1'b0;
        divisor = '0;
        #1;

        // Default divide: ticks at cycles 1 and 51, 25 high / 25 low
        do_reset("reset0");
        run("div50", 100, 50, 0, 0);

        // Load 3 at cycle 10: pending until the wrap at cycle 51
        do_reset("reset1");
        run("pre_load3", 9, 50, 0, 0);
        step(1'b1, 1'b1, 8'd3);
        expect_state("load3_edge", 9, 0, 1, 1);
        run("wait_load3", 40, 50, 10, 1);
        run("div3", 12, 3, 0, 0);

        // Divisor 0 clamps to 2
        run("div3_more", 1, 3, 0, 0);
        step(1'b1, 1'b1, 8'd0);
        expect_state("load0_edge", 1, 0, 0, 1);
        run("wait_load0", 1, 3, 2, 1);
        run("div2_from0", 6, 2, 0, 0);

        // Divisor 1 clamps to 2, loaded on a wrap with nothing pending
        step(1'b1, 1'b1, 8'd1);
        expect_state("load1_edge", 0, 1, 1, 1);
        run("wait_load1", 1, 2, 1, 1);
        run("div2_from1", 4, 2, 0, 0);

        // Enable low for 7 cycles inside the high phase at N=10
        step(1'b1, 1'b1, 8'd10);
        expect_state("load10_edge", 0, 1, 1, 1);
        run("wait_load10", 1, 2, 1, 1);
        run("div10_high", 3, 10, 0, 0);
        for (int k = 0; k < 7; k++) begin
            step(1'b0, 1'b0, '0);
            expect_state("frozen", 2, 0, 1, 0);
        end
        run("div10_resume", 7, 10, 3, 0);
        run("div10_next", 10, 10, 0, 0);

        // Load 6 on the wrap edge while 4 is pending: 4 first, then 6
        run("div10_pre4", 2, 10, 0, 0);
        step(1'b1, 1'b1, 8'd4);
        expect_state("load4_edge", 2, 0, 1, 1);
        run("wait_load4", 7, 10, 3, 1);
        step(1'b1, 1'b1, 8'd6);
        expect_state("load6_on_wrap", 0, 1, 1, 1);
        run("div4", 3, 4, 1, 1);
        run("div6", 6, 6, 0, 0);

        // Reset during a high phase discards the pending load
        run("div6_high", 2, 6, 0, 0);
        step(1'b1, 1'b1, 8'd9);
        expect_state("load9_edge", 2, 0, 1, 1);
        do_reset("reset_mid");
        run("div50_again", 52, 50, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
